sobel_stream: RTL
=================

SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 SHALL have parameter IMG_W, default 64, image width in pixels (legal range >= 3).
REQ-002 SHALL have parameter IMG_H, default 64, image height in pixels (legal range >= 3).
REQ-003 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-004 SHALL have parameter ADDR_W, default $clog2(IMG_W*IMG_H), output address width.
REQ-005 SHALL have one clock and a synchronous active-low reset: clk_i  in  1  clock, all state on rising edge.
REQ-006 rst_ni  in  1  synchronous active-low reset.
REQ-007 start_i  in  1  single-cycle frame start; samples mode_i/thresh_i.
REQ-008 mode_i  in  1  0 = saturated magnitude, 1 = binary threshold.
REQ-009 thresh_i  in  PIX_W+3  threshold for mode 1.
REQ-010 in_valid_i  in  1  input pixel valid.
REQ-011 in_ready_o  out  1  input pixel accepted when high with in_valid_i.
REQ-012 in_pixel_i  in  PIX_W  raster-order input pixel, unsigned.
REQ-013 out_valid_o  out  1  output pixel valid.
REQ-014 out_ready_i  in  1  sink ready.
REQ-015 out_pixel_o  out  PIX_W  edge result.
REQ-016 out_addr_o  out  ADDR_W  output-memory address = y*IMG_W + x of centre pixel.
REQ-017 out_last_o  out  1  high with the final output pixel of the frame.
REQ-018 finish_o  out  1  level; high from frame completion until next accepted start_i.

Function
REQ-019 States IDLE, RUN, DRAIN; IDLE->RUN on start_i; RUN->DRAIN on acceptance of pixel (IMG_H-1, IMG_W-1); DRAIN->IDLE on handshake of out_last_o pixel, setting finish_o.
REQ-020 start_i SHALL be ignored outside IDLE; on acceptance clear col/row counters and finish_o, latch mode_i and thresh_i.
REQ-021 in_ready_o = (state==RUN) && (!out_valid_o || out_ready_i).
REQ-022 Column counter increments per accepted pixel, wraps IMG_W-1 -> 0 and increments row counter.
REQ-023 Two line buffers (IMG_W x PIX_W each) hold rows r-1 and r-2; on accepting p(r,c): lb_r2[c] <= lb_r1[c], lb_r1[c] <= p.
REQ-024 3x3 window shifts left one column per accept; new right column = {lb_r2[c], lb_r1[c], p}.
REQ-025 When accepted pixel has r>=2 and c>=2, result for centre (r-1, c-1) SHALL be registered with out_valid_o high the next cycle (latency 1); otherwise no output.
REQ-026 Exactly (IMG_W-2)*(IMG_H-2) outputs per frame; border pixels not emitted.
REQ-027 Gx = (p02+2p12+p22)-(p00+2p10+p20), Gy = (p20+2p21+p22)-(p00+2p01+p02), signed PIX_W+4 bits, no overflow.
REQ-028 mag = |Gx|+|Gy|, unsigned PIX_W+3 bits (max 8*(2^PIX_W-1)).
REQ-029 Mode 0: out_pixel_o = min(mag, 2^PIX_W-1).
REQ-030 Mode 1: out_pixel_o = all-ones if mag >= thresh, else 0.
REQ-031 out_valid_o, out_pixel_o, out_addr_o, out_last_o SHALL hold stable while out_valid_o && !out_ready_i.
REQ-032 Simultaneous output handshake and new result load SHALL replace the output register with no bubble.
REQ-033 Line-buffer contents are not cleared between frames; rows 0/1 are overwritten before use.

Reset
REQ-034 On rst_ni low at a clock edge: state IDLE, counters 0, in_ready_o 0, out_valid_o 0, out_pixel_o 0, out_addr_o 0, out_last_o 0, finish_o 0.
REQ-035 Reset mid-frame SHALL abort the frame with no further outputs; next start_i begins a clean frame.

Verification
REQ-036 IMG_W=IMG_H=4, constant image 50, mode 0 -> 4 outputs of 0, addrs 5,6,9,10, out_last_o on addr 10, finish_o set.
REQ-037 PIX_W=8, cols 0-1 = 0, cols >=2 = 255, mode 0 -> centre col 1/2 mag 1020 -> out 255; interior elsewhere 0.
REQ-038 Same image, mode 1, thresh 1020 -> 255 where mag=1020; thresh 1021 -> all 0.
REQ-039 out_ready_i low 5 cycles with output pending -> out_valid_o held, data stable, in_ready_o low; release -> stream resumes, no loss/duplication.
REQ-040 start_i pulsed during RUN -> ignored, counts unaffected; rst_ni low mid-frame -> all outputs to reset values, new frame correct.

Source files
------------

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector over one raster-order frame.
// Accepts one pixel per in_valid_i/in_ready_o handshake and emits one result per interior pixel,
// one cycle after the pixel that completes its 3x3 neighbourhood is accepted.
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   start_i, mode_i,         frame start (IDLE only); latches mode (0 = saturated magnitude,
//   thresh_i                 1 = binary threshold) and threshold
//   in_valid_i/in_ready_o    input pixel handshake, in_pixel_i raster-order unsigned pixel
//   out_valid_o/out_ready_i  output handshake; out_pixel_o result, out_addr_o = y*IMG_W + x of
//                            the centre pixel, out_last_o marks the final result of the frame
//   finish_o                 level, high from frame completion until the next accepted start
module sobel_stream #(
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [PIX_W+2:0]  thresh_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PIX_W-1:0]  in_pixel_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PIX_W-1:0]  out_pixel_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o,
  output logic              finish_o
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned MW = PIX_W + 3;
  localparam int unsigned GW = PIX_W + 4;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e              r_state, w_state_next;
  logic [CW-1:0]       r_col;
  logic [RW-1:0]       r_row;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_mode;
  logic [MW-1:0]       r_thresh;
  logic                r_out_valid;
  logic [PIX_W-1:0]    r_out_pixel;
  logic [ADDR_W-1:0]   r_out_addr;
  logic                r_out_last;
  logic                r_finish;

  logic [PIX_W-1:0]    r_lb1 [IMG_W];   // row r-1
  logic [PIX_W-1:0]    r_lb2 [IMG_W];   // row r-2
  logic [PIX_W-1:0]    r_win [3][2];    // two most recent window columns; row 0 is the top

  logic                w_start_acc, w_in_acc, w_out_hs, w_col_last, w_row_last, w_emit;
  logic [PIX_W-1:0]    w_p [3][3];
  logic signed [GW-1:0] w_gx, w_gy;
  logic [GW-1:0]       w_ax, w_ay;
  logic [MW-1:0]       w_mag;
  logic [PIX_W-1:0]    w_res;
  logic [ADDR_W-1:0]   w_addr;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  assign w_start_acc = (r_state == StIdle) && start_i;
  assign in_ready_o  = (r_state == StRun) && (!r_out_valid || out_ready_i);
  assign w_in_acc    = in_valid_i && in_ready_o;
  assign w_out_hs    = r_out_valid && out_ready_i;
  assign w_col_last  = (r_col == CW'(IMG_W - 1));
  assign w_row_last  = (r_row == RW'(IMG_H - 1));
  assign w_emit      = w_in_acc && (r_row >= RW'(2)) && (r_col >= CW'(2));
  // Centre sits one row up and one column left of the pixel being accepted.
  assign w_addr      = r_idx - ADDR_W'(IMG_W + 1);

  // Window as it will look after this accept: shifted left, new right column appended.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_p[i][0] = r_win[i][0];
      w_p[i][1] = r_win[i][1];
    end
    w_p[0][2] = r_lb2[r_col];
    w_p[1][2] = r_lb1[r_col];
    w_p[2][2] = in_pixel_i;
  end

  always_comb begin
    w_gx  = (ext(w_p[0][2]) + (ext(w_p[1][2]) <<< 1) + ext(w_p[2][2]))
          - (ext(w_p[0][0]) + (ext(w_p[1][0]) <<< 1) + ext(w_p[2][0]));
    w_gy  = (ext(w_p[2][0]) + (ext(w_p[2][1]) <<< 1) + ext(w_p[2][2]))
          - (ext(w_p[0][0]) + (ext(w_p[0][1]) <<< 1) + ext(w_p[0][2]));
    w_ax  = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    w_ay  = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    w_mag = w_ax[MW-1:0] + w_ay[MW-1:0];
    if (r_mode) begin
      w_res = (w_mag >= r_thresh) ? '1 : '0;
    end else begin
      w_res = (|w_mag[MW-1:PIX_W]) ? '1 : w_mag[PIX_W-1:0];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (start_i) w_state_next = StRun;
      StRun:   if (w_in_acc && w_col_last && w_row_last) w_state_next = StDrain;
      StDrain: if (w_out_hs && r_out_last) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_col       <= '0;
      r_row       <= '0;
      r_idx       <= '0;
      r_mode      <= 1'b0;
      r_thresh    <= '0;
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
      r_out_addr  <= '0;
      r_out_last  <= 1'b0;
      r_finish    <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_col    <= '0;
        r_row    <= '0;
        r_idx    <= '0;
        r_finish <= 1'b0;
        r_mode   <= mode_i;
        r_thresh <= thresh_i;
      end
      if (w_in_acc) begin
        r_idx <= r_idx + ADDR_W'(1);
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      // in_ready_o guarantees the output slot is free (or draining) whenever w_emit is high.
      if (w_emit) begin
        r_out_valid <= 1'b1;
        r_out_pixel <= w_res;
        r_out_addr  <= w_addr;
        r_out_last  <= w_col_last && w_row_last;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
      if ((r_state == StDrain) && w_out_hs && r_out_last) begin
        r_finish <= 1'b1;
      end
    end
  end

  // Pixel storage is never cleared; rows 0 and 1 are rewritten before any output uses them.
  always_ff @(posedge clk_i) begin
    if (w_in_acc) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= in_pixel_i;
      for (int i = 0; i < 3; i++) begin
        r_win[i][0] <= w_p[i][1];
        r_win[i][1] <= w_p[i][2];
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_pixel_o = r_out_pixel;
  assign out_addr_o  = r_out_addr;
  assign out_last_o  = r_out_last;
  assign finish_o    = r_finish;

endmodule
